// File: rtl/dm_cache_mem_responder.sv
// Purpose: backing memory behind the direct-mapped cache; serves line-fill reads and word writes.
// Latency: first response beat is valid LATENCY cycles after request accept, then one beat per handshake.
// Backpressure: one request in flight; req_ready low outside IDLE, response beats hold while resp_ready is low.
module dm_cache_mem_responder #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_WORDS      = 256,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int BEAT_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [IDX_W-1:0] LINE_MASK = ~(IDX_W'(WORDS_PER_LINE - 1));

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_resp_valid;
    logic                r_resp_last;
    logic [DATA_W-1:0]   r_resp_data;

    // Storage holds (data XOR word index) so an all-zero power-up image reads back as mem[i] = i.
    logic [DATA_W-1:0]   r_mem [MEM_WORDS];

    logic [IDX_W-1:0]    w_base;
    logic [IDX_W-1:0]    w_rd_addr;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_commit;
    logic                w_mem_we;
    logic                w_hs;
    logic                w_unused_addr;

    // Byte-address bits outside the word index are deliberately ignored.
    assign w_unused_addr = ^req_addr;

    assign w_base    = r_idx & LINE_MASK;
    assign w_commit  = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_mem_we  = !reset && w_commit && r_we;
    assign w_hs      = r_resp_valid && resp_ready;
    assign req_ready = (r_state == S_IDLE) && !reset;

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_last  = r_resp_last;

    // Pick the word feeding the next beat: line base on entry to BURST, else the following word.
    always_comb begin
        w_rd_addr = w_base;
        if (r_state == S_BURST) begin
            w_rd_addr = w_base + IDX_W'(r_beat) + IDX_W'(1);
        end
        w_rd_data = r_mem[w_rd_addr] ^ DATA_W'(w_rd_addr);
    end

    // Next-state decode for the request/wait/burst sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid)            w_next = S_WAIT;
            S_WAIT:  if (w_commit)             w_next = S_BURST;
            S_BURST: if (w_hs && r_resp_last)  w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any request in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture, latency countdown and response beat generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_beat       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_idx   <= req_addr[IDX_W+1:2];
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_resp_valid <= 1'b1;
                        if (r_we) begin
                            r_resp_data <= r_wdata;
                            r_resp_last <= 1'b1;
                        end else begin
                            r_resp_data <= w_rd_data;
                            r_beat      <= '0;
                            r_resp_last <= (WORDS_PER_LINE == 1);
                        end
                    end
                end
                S_BURST: begin
                    if (w_hs) begin
                        if (r_resp_last) begin
                            r_resp_valid <= 1'b0;
                            r_resp_last  <= 1'b0;
                        end else begin
                            r_beat      <= r_beat + BEAT_W'(1);
                            r_resp_data <= w_rd_data;
                            r_resp_last <= ((r_beat + BEAT_W'(1)) == BEAT_W'(WORDS_PER_LINE - 1));
                        end
                    end
                end
                default: r_resp_valid <= 1'b0;
            endcase
        end
    end

    // Word write commits on the WAIT->BURST edge; storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata ^ DATA_W'(r_idx);
        end
    end

endmodule
